// File: rtl/ops_sort_pkg.sv
// ---------------------------------------------------------------------------
// ops_sort_pkg
// Shared definitions for the sort / unsort pair in the ops chain.
//   sort_state_e : control states used by the iterative unsort scatter
//   pos_width()  : width of an original-position tag. The sorter and
//                  unsort_scatter both derive their tag width from this, so
//                  the two always agree. The extra MSB lets a tag equal to or
//                  above the element count be represented and flagged.
//   idx_width()  : width of a counter that walks the element list
// ---------------------------------------------------------------------------
package ops_sort_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCATTER = 2'd1,
    FINISH  = 2'd2
  } sort_state_e;

  function automatic int pos_width(input int n);
    return $clog2(n) + 1;
  endfunction

  // A single-element list still needs a 1-bit counter to keep slices legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/perm_tracker.sv
// ---------------------------------------------------------------------------
// perm_tracker
// Tracks which destination slots have already been claimed while a tag list
// is walked one element per cycle, and remembers whether any tag was bad.
// Ports:
//   clk, reset : rising-edge clock, synchronous active-high reset
//   clear      : empties the seen mask and the sticky error (new operation)
//   valid      : pos is a tag to be checked and, if accepted, recorded
//   pos        : candidate destination slot (original index)
//   accept     : combinational, pos is in range and not yet claimed
//   err        : sticky, some checked tag was out of range or a duplicate
// ---------------------------------------------------------------------------
module perm_tracker
  import ops_sort_pkg::*;
#(
  parameter int INPUTVALS = 16,
  parameter int POSW      = pos_width(INPUTVALS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic            valid,
  input  logic [POSW-1:0] pos,
  output logic            accept,
  output logic            err
);

  localparam int IDXW = idx_width(INPUTVALS);

  logic [INPUTVALS-1:0] seen_q, seen_d;
  logic                 err_q, err_d;
  logic                 in_range;
  logic [IDXW-1:0]      slot;

  // The range test uses the full tag width, so any tag >= INPUTVALS
  // (including every tag with the MSB set) is refused before the low bits
  // are ever used to look up the mask.
  always_comb begin
    in_range = (pos < POSW'(INPUTVALS));
    slot     = pos[IDXW-1:0];
    accept   = in_range && !seen_q[slot];
  end

  // Clear wins over a check in the same cycle; a refused tag only raises
  // the sticky flag and leaves the mask untouched.
  always_comb begin
    seen_d = seen_q;
    err_d  = err_q;
    if (clear) begin
      seen_d = '0;
      err_d  = 1'b0;
    end else if (valid) begin
      if (accept) begin
        seen_d[slot] = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seen_q <= '0;
      err_q  <= 1'b0;
    end else begin
      seen_q <= seen_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/unsort_scatter.sv
// ---------------------------------------------------------------------------
// unsort_scatter
// Undoes the insertion sorter: each sorted value is written back to the
// original index carried in its position tag, restoring input order.
// One element is scattered per cycle; total latency is INPUTVALS+2 cycles
// from the accepted start to the done pulse.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   unsortstart  : start request, only honoured while idle
//   sorted_in    : values in sorted order (captured at start)
//   positions_in : original index of each sorted_in element (captured)
//   busy         : operation in progress, drops together with unsortdone
//   unsortdone   : one-cycle pulse, restored has just been updated
//   restored     : values in original order, held until the next done
//   perm_error   : pulses with unsortdone when the tags were not a
//                  permutation (out-of-range or duplicate entries)
//   error        : one-cycle pulse if the control state became illegal
// ---------------------------------------------------------------------------
module unsort_scatter
  import ops_sort_pkg::*;
#(
  parameter int INPUTVALS      = 16,
  parameter int INPUTBITWIDTHS = 32,
  parameter int POSW           = pos_width(INPUTVALS)
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     unsortstart,
  input  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] sorted_in,
  input  logic [INPUTVALS-1:0][POSW-1:0]           positions_in,
  output logic                                     busy,
  output logic                                     unsortdone,
  output logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] restored,
  output logic                                     perm_error,
  output logic                                     error
);

  localparam int IDXW = idx_width(INPUTVALS);

  sort_state_e state_q, state_d;

  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] val_q, val_d;
  logic [INPUTVALS-1:0][POSW-1:0]           pos_q, pos_d;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] working_q, working_d;
  logic [INPUTVALS-1:0][INPUTBITWIDTHS-1:0] restored_q, restored_d;
  logic [IDXW-1:0]                          idx_q, idx_d;

  logic busy_q, busy_d;
  logic done_q, done_d;
  logic perm_err_q, perm_err_d;
  logic error_q, error_d;

  logic                      trk_clear;
  logic                      trk_valid;
  logic                      trk_accept;
  logic                      trk_err;
  logic [POSW-1:0]           cur_pos;
  logic [INPUTBITWIDTHS-1:0] cur_val;

  // Element currently being scattered, taken from the captured copy so that
  // the upstream buses may change freely once the operation has started.
  always_comb begin
    cur_pos = pos_q[idx_q];
    cur_val = val_q[idx_q];
  end

  perm_tracker #(
    .INPUTVALS (INPUTVALS),
    .POSW      (POSW)
  ) u_perm_tracker (
    .clk    (clk),
    .reset  (reset),
    .clear  (trk_clear),
    .valid  (trk_valid),
    .pos    (cur_pos),
    .accept (trk_accept),
    .err    (trk_err)
  );

  // Next-state and datapath control. The done, perm_error and error pulses
  // default low so that each lasts exactly one cycle. An illegal state
  // wipes the working context as a reset would, but keeps the last good
  // restored result visible downstream.
  always_comb begin
    state_d    = state_q;
    val_d      = val_q;
    pos_d      = pos_q;
    working_d  = working_q;
    restored_d = restored_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    perm_err_d = 1'b0;
    error_d    = 1'b0;
    trk_clear  = 1'b0;
    trk_valid  = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (unsortstart) begin
          val_d     = sorted_in;
          pos_d     = positions_in;
          working_d = '0;
          idx_d     = '0;
          trk_clear = 1'b1;
          busy_d    = 1'b1;
          state_d   = SCATTER;
        end
      end

      // Refused elements are simply dropped; their target slot keeps the
      // zero written at start, and the tracker remembers the fault.
      SCATTER: begin
        trk_valid = 1'b1;
        if (trk_accept) begin
          working_d[cur_pos[IDXW-1:0]] = cur_val;
        end
        if (idx_q == IDXW'(INPUTVALS - 1)) begin
          state_d = FINISH;
        end else begin
          idx_d = idx_q + IDXW'(1);
        end
      end

      // The FSM is already idle while done is high, so a new start can be
      // accepted in that same cycle.
      FINISH: begin
        restored_d = working_q;
        done_d     = 1'b1;
        perm_err_d = trk_err;
        busy_d     = 1'b0;
        state_d    = IDLE;
      end

      default: begin
        error_d   = 1'b1;
        val_d     = '0;
        pos_d     = '0;
        working_d = '0;
        idx_d     = '0;
        trk_clear = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // All state, including the visible result, clears on reset; a reset
  // during an operation therefore aborts it with no done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      val_q      <= '0;
      pos_q      <= '0;
      working_q  <= '0;
      restored_q <= '0;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      perm_err_q <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      val_q      <= val_d;
      pos_q      <= pos_d;
      working_q  <= working_d;
      restored_q <= restored_d;
      idx_q      <= idx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      perm_err_q <= perm_err_d;
      error_q    <= error_d;
    end
  end

  assign busy       = busy_q;
  assign unsortdone = done_q;
  assign restored   = restored_q;
  assign perm_error = perm_err_q;
  assign error      = error_q;

endmodule

// File: tb/tb_unsort_scatter.sv
// ---------------------------------------------------------------------------
// tb_unsort_scatter
// Directed and randomised checks of unsort_scatter against a simple
// reference: walk the tag list in order, place each value at its tag unless
// the tag is out of range or already used, and flag any refused tag.
// ---------------------------------------------------------------------------
module tb_unsort_scatter;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int PW = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 unsortstart;
  logic [N-1:0][W-1:0]  sorted_in;
  logic [N-1:0][PW-1:0] positions_in;
  logic                 busy;
  logic                 unsortdone;
  logic [N-1:0][W-1:0]  restored;
  logic                 perm_error;
  logic                 error;

  int       total = 0;
  int       bad   = 0;
  logic [W-1:0] expVal [N];
  logic     expErr;
  int       doneCycle;
  logic     busyGap;
  int       extraDone;
  logic [W-1:0] keep3;

  unsort_scatter #(
    .INPUTVALS      (N),
    .INPUTBITWIDTHS (W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .unsortstart  (unsortstart),
    .sorted_in    (sorted_in),
    .positions_in (positions_in),
    .busy         (busy),
    .unsortdone   (unsortdone),
    .restored     (restored),
    .perm_error   (perm_error),
    .error        (error)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected result straight from the scatter rules applied to the inputs.
  function automatic void buildModel();
    bit seen [N];
    int p;
    for (int i = 0; i < N; i++) begin
      expVal[i] = '0;
      seen[i]   = 1'b0;
    end
    expErr = 1'b0;
    for (int i = 0; i < N; i++) begin
      p = int'(positions_in[i]);
      if (p < N && !seen[p]) begin
        expVal[p] = sorted_in[i];
        seen[p]   = 1'b1;
      end else begin
        expErr = 1'b1;
      end
    end
  endfunction

  // Called at a falling edge; pulses start across exactly one rising edge.
  task automatic applyStimulus();
    unsortstart = 1'b1;
    @(posedge clk);
    @(negedge clk);
    unsortstart = 1'b0;
  endtask

  // Counts rising edges after the start edge until done is seen (bounded).
  // midStartAt > 0 raises start for one edge while the scatter is running.
  task automatic waitDone(input int midStartAt);
    doneCycle = -1;
    busyGap   = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      @(negedge clk);
      unsortstart = 1'b0;
      if (unsortdone) begin
        doneCycle = n;
        break;
      end
      if (!busy) busyGap = 1'b1;
      if (n == midStartAt) unsortstart = 1'b1;
    end
  endtask

  task automatic checkResult(input string name);
    checkOutput({name, " latency"}, doneCycle, 17);
    checkOutput({name, " busy_hold"}, busyGap, 1'b0);
    checkOutput({name, " perm_error"}, perm_error, expErr);
    checkOutput({name, " error"}, error, 1'b0);
    for (int i = 0; i < N; i++)
      checkOutput($sformatf("%s restored[%0d]", name, i), restored[i], expVal[i]);
  endtask

  task automatic checkTail(input string name);
    @(posedge clk);
    @(negedge clk);
    checkOutput({name, " done_single"}, unsortdone, 1'b0);
    checkOutput({name, " perm_error_pulse"}, perm_error, 1'b0);
    checkOutput({name, " busy_after"}, busy, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    unsortstart  = 1'b0;
    sorted_in    = '0;
    positions_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    checkOutput("reset busy", busy, 1'b0);
    checkOutput("reset done", unsortdone, 1'b0);
    checkOutput("reset perm_error", perm_error, 1'b0);
    checkOutput("reset error", error, 1'b0);
    checkOutput("reset restored", restored, '0);

    // Identity, inputs scrambled after start to prove the capture holds
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(i);
      sorted_in[i]    = W'(i * 10);
    end
    buildModel();
    applyStimulus();
    checkOutput("ident busy_start", busy, 1'b1);
    for (int i = 0; i < N; i++) begin
      sorted_in[i]    = $urandom;
      positions_in[i] = PW'(0);
    end
    waitDone(0);
    checkResult("ident");
    checkOutput("ident restored[5] const", restored[5], 32'd50);
    checkTail("ident");

    // Reverse
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(15 - i);
      sorted_in[i]    = W'(i);
    end
    buildModel();
    applyStimulus();
    waitDone(0);
    checkResult("rev");
    checkOutput("rev restored[0] const", restored[0], 32'd15);
    checkTail("rev");

    // Duplicate tag: tags 3 and 4 both point at 7, slot 8 never written
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(i);
      sorted_in[i]    = $urandom;
    end
    positions_in[3] = PW'(7);
    positions_in[4] = PW'(7);
    positions_in[7] = PW'(3);
    positions_in[8] = PW'(4);
    keep3 = sorted_in[3];
    buildModel();
    applyStimulus();
    waitDone(0);
    checkResult("dup");
    checkOutput("dup slot7", restored[7], keep3);
    checkOutput("dup slot8", restored[8], '0);
    checkOutput("dup perm_error const", perm_error, 1'b1);
    checkTail("dup");

    // Out-of-range tag plus a start request in the middle of the scatter
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(i);
      sorted_in[i]    = $urandom;
    end
    positions_in[0] = PW'(16);
    buildModel();
    applyStimulus();
    waitDone(5);
    checkResult("oor");
    checkOutput("oor slot0", restored[0], '0);
    checkTail("oor");
    extraDone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (unsortdone) extraDone++;
    end
    checkOutput("oor no_queued_done", extraDone, 0);

    // Reset five cycles into the scatter
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(15 - i);
      sorted_in[i]    = $urandom;
    end
    applyStimulus();
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort busy", busy, 1'b0);
    checkOutput("abort restored", restored, '0);
    extraDone = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (unsortdone) extraDone++;
    end
    checkOutput("abort no_done", extraDone, 0);
    buildModel();
    applyStimulus();
    waitDone(0);
    checkResult("post_abort");
    checkTail("post_abort");

    // Restart accepted in the cycle where done is high
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'(i);
      sorted_in[i]    = $urandom;
    end
    buildModel();
    applyStimulus();
    waitDone(0);
    checkResult("b2b_first");
    for (int i = 0; i < N; i++) begin
      positions_in[i] = PW'((i + 3) % N);
      sorted_in[i]    = $urandom;
    end
    buildModel();
    applyStimulus();
    checkOutput("b2b busy_restart", busy, 1'b1);
    waitDone(0);
    checkResult("b2b_second");
    checkTail("b2b_second");

    // Random permutations, with some runs using arbitrary (mostly bad) tags
    for (int t = 0; t < 24; t++) begin
      int order [N];
      int j;
      int tmp;
      for (int i = 0; i < N; i++) order[i] = i;
      for (int i = N - 1; i > 0; i--) begin
        j        = int'($urandom_range(0, i));
        tmp      = order[i];
        order[i] = order[j];
        order[j] = tmp;
      end
      for (int i = 0; i < N; i++) begin
        sorted_in[i] = $urandom;
        if (t % 4 == 3) positions_in[i] = PW'($urandom_range(0, 31));
        else            positions_in[i] = PW'(order[i]);
      end
      buildModel();
      applyStimulus();
      waitDone(0);
      checkResult($sformatf("rand%0d", t));
      checkTail($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/unsort_scatter.md
Name: unsort_scatter

Overview:
- Inverse companion to the insertion sorter: takes a sorted value list plus the per-element original-position tags the sorter emits, and scatters each value back to its original index, restoring input order.
- Sits downstream of the sorter in the ops chain, so an operation can be performed in sorted domain and the results returned in original order.
- Iterative, one element per cycle. Validates that the position list is a true permutation.

Parameters:
- INPUTVALS, 16, number of elements; must match the paired sorter.
- INPUTBITWIDTHS, 32, bit width of each value.
- POSW, $clog2(INPUTVALS)+1, position tag width; matches the sorter's sorted_positions element width.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- unsortstart  in  1  start pulse, sampled only in IDLE.
- sorted_in  in  [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  values in sorted order.
- positions_in  in  [INPUTVALS-1:0][POSW-1:0]  original index of each sorted_in element.
- busy  out  1  high from the cycle after start is accepted until unsortdone.
- unsortdone  out  1  one-cycle pulse when restored is valid.
- restored  out  [INPUTVALS-1:0][INPUTBITWIDTHS-1:0]  values in original order, held until next done.
- perm_error  out  1  one-cycle pulse coincident with unsortdone if the positions were not a valid permutation.
- error  out  1  one-cycle pulse if the FSM reaches an illegal state.

Behaviour:
- Reset (synchronous, reset==1 at edge):
  - all outputs 0, including restored;
  - internal working array, seen mask and index counter 0;
  - FSM to IDLE.
- States:
  - IDLE:
    - On unsortstart==1, capture sorted_in and positions_in into internal registers, clear working array, seen mask, error flag, and set idx=0.
    - Transition to SCATTER.
    - The captured copy is authoritative; later input changes are ignored.
  - SCATTER, one element per cycle:
    - Let p = pos_q[idx].
    - If p < INPUTVALS and seen[p]==0: write working[p] <= val_q[idx] and set seen[p].
    - Otherwise (p out of range, or duplicate): drop the element and set the sticky err flag.
    - If idx==INPUTVALS-1, go to FINISH; otherwise increment idx.
  - FINISH:
    - restored <= working; unsortdone <= 1; perm_error <= err; go to IDLE.
- Timing:
  - Start sampled at edge k; busy high after edges k .. k+INPUTVALS.
  - unsortdone and perm_error high for exactly one cycle after edge k+INPUTVALS+1.
  - Total latency INPUTVALS+2 cycles.
- Boundaries:
  - unsortstart while not IDLE is ignored; no queueing.
  - Restart is allowed in the cycle where unsortdone is high, because the FSM is already in IDLE.
  - Slots never written on error read 0 in restored.
  - A full-range out-of-range tag is detected via the MSB of POSW, and any value ≥ INPUTVALS is flagged.
  - Reset mid-operation aborts immediately with no done pulse; restored clears to 0.
  - Unknown FSM state:
    - error pulses 1 cycle;
    - internal state clears as at reset, restored is held;
    - FSM returns to IDLE.
- Defaults every cycle: unsortdone, perm_error and error driven 0 unless set above.

Decomposition:
- Shared package ops_sort_pkg:
  - FSM state enum, {IDLE, SCATTER, FINISH} as logic[1:0];
  - a POSW width function, so the sorter and unsort_scatter agree on the tag width.
- One natural sub-module, perm_tracker:
  - holds the seen mask;
  - takes p plus a valid strobe;
  - returns accept (p in range and unseen) and a sticky err flag;
  - clears on start.
- All other logic stays in unsort_scatter.

Test Plan:
- Identity: positions_in[i]=i, sorted_in[i]=i*10 → after 18 cycles restored[i]=i*10, perm_error=0, unsortdone single pulse.
- Reverse: positions_in[i]=15-i, sorted_in[i]=i → restored[i]=15-i, perm_error=0.
- Round trip: random 16 values into the sorter, its sorted/sorted_positions into unsort_scatter → restored equals the original needs_sorting bit-for-bit over 1000 seeds.
- Duplicate tag: positions_in[3]=positions_in[4]=7, other tags a permutation missing 8 → restored[7]=sorted_in[3], restored[8]=0, perm_error=1 with unsortdone.
- Out-of-range tag: positions_in[0]=16 → that value dropped, perm_error=1; unsortstart pulsed mid-SCATTER is ignored, and exactly one done pulse occurs.
- Reset at cycle 5 of SCATTER → no unsortdone, restored=0, busy=0 next cycle; a fresh start then completes normally in 18 cycles.
